rtc_edit_regs: RTL and testbench
================================

Name: rtc_edit_regs

Overview:
- Write-register bank upstream of the VGA data mux: produces the three edit bytes RG1/RG2/RG3 and the mux select line.
- In idle, it shadows the time fields read from the RTC bus.
- In edit mode, the user adjusts BCD fields with push-buttons; the VGA shows the edited values live.
- On exit, it pulses a write request so the RTC controller commits RG1..RG3.

Parameters:
- MAX1, 8'h23, BCD maximum of field 1 (hours)
- MAX2, 8'h59, BCD maximum of field 2 (minutes)
- MAX3, 8'h59, BCD maximum of field 3 (seconds)
- MIN1/MIN2/MIN3, 8'h00 each, BCD minimum per field
- BLINK_DIV, 25_000_000, clk cycles per blink half-period (used only with BLINK_EN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- edit_en  in  1  level switch; 1 = edit mode requested (asynchronous, synchronised internally)
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced buttons (asynchronous, synchronised internally)
- cap_we  in  1  capture strobe from the RTC read sequencer
- cap_sel  in  2  capture target: 0=RG1, 1=RG2, 2=RG3, 3=ignored
- cap_data  in  8  BCD byte from the RTC bus
- RG1, RG2, RG3  out  8 each  edit registers (feed the mux)
- seleccion  out  1  mux select; 1 while editing
- field  out  2  currently selected field, 0..2
- wr_req  out  1  one-cycle commit pulse
- blink  out  1  cursor blink for the selected field

Behaviour:
- Reset values: RG1/RG2/RG3 = MIN1/MIN2/MIN3; seleccion=0; field=0; wr_req=0; blink=0; FSM=IDLE.
- Reset is effective immediately, including mid-edit; no wr_req is issued on reset.
- Synchronisation:
  - All five user inputs pass through two flops.
  - Buttons are rising-edge detected after the synchroniser.
  - An input going high is acted on at the 3rd rising clk edge after it is sampled high.
  - edit_en is level-sensed after the synchroniser.
- IDLE:
  - seleccion=0.
  - cap_we=1 writes cap_data into the register chosen by cap_sel on the next edge; cap_sel=3 writes nothing.
  - Buttons are ignored.
  - Synchronised edit_en=1 -> EDIT with field=0.
- EDIT:
  - seleccion=1; cap_we is ignored.
  - up edge: the selected field increments in BCD (x9 -> (x+1)0); MAX wraps to MIN.
  - down edge: the selected field decrements in BCD; MIN wraps to MAX.
  - A field holding invalid BCD (either nibble > 9) or a value outside MIN..MAX goes to MIN on up and to MAX on down.
  - right edge: field+1, 2 -> 0. left edge: field-1, 0 -> 2.
  - up and down edges in the same cycle: no change. left and right in the same cycle: no change.
  - up/down together with left/right: the value change applies to the old field, then the field moves.
  - Synchronised edit_en=0 -> COMMIT; button edges in that cycle are discarded.
- COMMIT:
  - Lasts exactly one cycle: wr_req=1, seleccion stays 1, then -> IDLE.
  - If edit_en re-asserts during COMMIT, the FSM still goes to IDLE and re-enters EDIT on the next cycle.
- wr_req is a registered output, high for exactly 1 cycle per edit session.

Optional Feature:
- Macro: RTC_EDIT_BLINK_EN.
- Defined:
  - Free-running counter modulo BLINK_DIV, cleared on entry to EDIT and on any field move.
  - blink toggles at each wrap while in EDIT and is forced 0 outside EDIT.
  - blink starts at 1 on EDIT entry.
- Undefined: blink is tied to 0; no counter logic is synthesised.

Decomposition:
- Shared package rtc_pkg holds:
  - FSM state type (IDLE, EDIT, COMMIT)
  - field index constants F_HOUR=0, F_MIN=1, F_SEC=2
  - BCD limit constants for default field ranges
- One natural sub-module: bcd_step, combinational; inputs value, min, max, dir; output next value including wrap and invalid-value handling. Instantiated once and muxed by field.

Test Plan:
- Reset then capture: cap_we with cap_sel=1, cap_data=8'h37 -> RG2=8'h37 next edge. cap_sel=3 -> no register changes. seleccion=0 throughout.
- Edit increment wrap: RG1=8'h23, edit_en=1, one up pulse -> RG1=8'h00. With RG2=8'h09, right then up -> RG2=8'h10, field=1.
- Decrement and invalid value: RG3=8'h00, field=2, down -> RG3=8'h59. RG3 captured as 8'h7A before edit, up -> RG3=8'h00.
- Field navigation: left at field=0 -> field=2. Simultaneous up+down -> RG unchanged. Simultaneous left+right -> field unchanged.
- Commit: drop edit_en -> exactly one wr_req pulse, then seleccion=0. cap_we asserted during EDIT -> ignored. Assert rst_n=0 mid-EDIT -> RGs return to MIN values, no wr_req.
- BLINK_EN build with BLINK_DIV=4: in EDIT, blink toggles every 4 cycles; a field move restarts the phase. Non-BLINK build: blink constant 0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC edit-register bank: FSM states,
// field indices and default BCD limits per field.
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] F_HOUR = 2'd0;
  localparam logic [1:0] F_MIN  = 2'd1;
  localparam logic [1:0] F_SEC  = 2'd2;

  localparam logic [7:0] BCD_MAX_HOUR = 8'h23;
  localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
  localparam logic [7:0] BCD_MAX_SEC  = 8'h59;
  localparam logic [7:0] BCD_MIN_ANY  = 8'h00;

endpackage

// File: rtl/bcd_step.sv
// Combinational one-step BCD up/down counter with wrap between min and max.
// Values that are not valid BCD or lie outside min..max snap to min (up) or max (down).
module bcd_step (
  input  logic [7:0] value,
  input  logic [7:0] min,
  input  logic [7:0] max,
  input  logic       dir,
  output logic [7:0] next
);

  logic valid;

  always_comb begin
    valid = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) &&
            (value >= min) && (value <= max);
    next  = value;
    if (dir) begin
      if (!valid || value == max)  next = min;
      else if (value[3:0] == 4'd9) next = {value[7:4] + 4'd1, 4'd0};
      else                         next = value + 8'd1;
    end else begin
      if (!valid || value == min)  next = max;
      else if (value[3:0] == 4'd0) next = {value[7:4] - 4'd1, 4'd9};
      else                         next = value - 8'd1;
    end
  end

endmodule

// File: rtl/rtc_edit_regs.sv
// Edit-register bank feeding the VGA data mux: shadows RTC time in idle, lets the
// user edit BCD fields with buttons, pulses wr_req on exit. Optional blink: RTC_EDIT_BLINK_EN.
module rtc_edit_regs
  import rtc_pkg::*;
#(
  parameter logic [7:0] MAX1      = BCD_MAX_HOUR,
  parameter logic [7:0] MAX2      = BCD_MAX_MIN,
  parameter logic [7:0] MAX3      = BCD_MAX_SEC,
  parameter logic [7:0] MIN1      = BCD_MIN_ANY,
  parameter logic [7:0] MIN2      = BCD_MIN_ANY,
  parameter logic [7:0] MIN3      = BCD_MIN_ANY,
  parameter int         BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       edit_en,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       cap_we,
  input  logic [1:0] cap_sel,
  input  logic [7:0] cap_data,
  output logic [7:0] RG1,
  output logic [7:0] RG2,
  output logic [7:0] RG3,
  output logic       seleccion,
  output logic [1:0] field,
  output logic       wr_req,
  output logic       blink
);

  // Input order in the sync chain: {edit_en, up, down, left, right}
  logic [4:0] in_p0, in_p1;
  logic [3:0] btn_p2;
  logic       edit_lvl, up_e, down_e, left_e, right_e;

  state_t     state_q, state_d;
  logic       entry, act, step_en, move_en;
  logic [1:0] field_nxt;
  logic [7:0] cur_val, cur_min, cur_max, step_val;

  assign edit_lvl = in_p1[4];
  assign {up_e, down_e, left_e, right_e} = in_p1[3:0] & ~btn_p2;
  assign seleccion = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (edit_lvl)  state_d = EDIT;
      EDIT:    if (!edit_lvl) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    entry   = (state_q == IDLE) && (state_d == EDIT);
    // Button edges in the cycle that leaves EDIT are dropped.
    act     = (state_q == EDIT) && edit_lvl;
    step_en = act && (up_e ^ down_e);
    move_en = act && (left_e ^ right_e);

    if (right_e) field_nxt = (field == F_SEC)  ? F_HOUR : field + 2'd1;
    else         field_nxt = (field == F_HOUR) ? F_SEC  : field - 2'd1;

    case (field)
      F_HOUR:  begin cur_val = RG1; cur_min = MIN1; cur_max = MAX1; end
      F_MIN:   begin cur_val = RG2; cur_min = MIN2; cur_max = MAX2; end
      default: begin cur_val = RG3; cur_min = MIN3; cur_max = MAX3; end
    endcase
  end

  bcd_step u_step (
    .value (cur_val),
    .min   (cur_min),
    .max   (cur_max),
    .dir   (up_e),
    .next  (step_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_p0   <= '0;
      in_p1   <= '0;
      btn_p2  <= '0;
      state_q <= IDLE;
      wr_req  <= 1'b0;
      field   <= F_HOUR;
      RG1     <= MIN1;
      RG2     <= MIN2;
      RG3     <= MIN3;
    end else begin
      in_p0   <= {edit_en, btn_up, btn_down, btn_left, btn_right};
      in_p1   <= in_p0;
      btn_p2  <= in_p1[3:0];
      state_q <= state_d;
      wr_req  <= (state_d == COMMIT);

      if (entry)        field <= F_HOUR;
      else if (move_en) field <= field_nxt;

      // Value change targets the field selected before any move in this cycle.
      if (state_q == IDLE && cap_we) begin
        case (cap_sel)
          2'd0:    RG1 <= cap_data;
          2'd1:    RG2 <= cap_data;
          2'd2:    RG3 <= cap_data;
          default: ;
        endcase
      end else if (step_en) begin
        case (field)
          F_HOUR:  RG1 <= step_val;
          F_MIN:   RG2 <= step_val;
          default: RG3 <= step_val;
        endcase
      end
    end
  end

`ifdef RTC_EDIT_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else begin
      if (entry || move_en) begin
        blink_cnt <= '0;
        blink_q   <= 1'b1;
      end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        if (state_q == EDIT) blink_q <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      if (state_d != EDIT) blink_q <= 1'b0;
    end
  end

  assign blink = blink_q;
`else
  logic unused_blink_div;
  assign unused_blink_div = (BLINK_DIV > 0);
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_edit_regs.sv
// Directed bench for rtc_edit_regs: capture, BCD edit/wrap, navigation, commit, reset.
// Blink expectations follow RTC_EDIT_BLINK_EN when defined.
module tb_rtc_edit_regs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       edit_en, btn_up, btn_down, btn_left, btn_right;
  logic       cap_we;
  logic [1:0] cap_sel;
  logic [7:0] cap_data;
  logic [7:0] RG1, RG2, RG3;
  logic       seleccion, wr_req, blink;
  logic [1:0] field;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rtc_edit_regs #(.BLINK_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .edit_en   (edit_en),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .cap_we    (cap_we),
    .cap_sel   (cap_sel),
    .cap_data  (cap_data),
    .RG1       (RG1),
    .RG2       (RG2),
    .RG3       (RG3),
    .seleccion (seleccion),
    .field     (field),
    .wr_req    (wr_req),
    .blink     (blink)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [1:0] sel, input logic [7:0] data);
    cap_we = 1'b1; cap_sel = sel; cap_data = data;
    tick();
    cap_we = 1'b0;
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    tick();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    repeat (3) tick();
  endtask

  // Entry happens on the third edge after edit_en is first sampled high.
  task automatic enter_edit();
    edit_en = 1'b1;
    repeat (3) tick();
  endtask

  logic [7:0] blink_exp0, blink_exp1;
  int wr_cnt, wr_at;

  initial begin
    rst_n = 1'b0; edit_en = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    cap_we = 0; cap_sel = 2'd0; cap_data = 8'h00;
`ifdef RTC_EDIT_BLINK_EN
    blink_exp0 = 8'd1; blink_exp1 = 8'd0;
`else
    blink_exp0 = 8'd0; blink_exp1 = 8'd0;
`endif
    repeat (3) tick();
    chk("rst_rg1", RG1, 8'h00);
    chk("rst_rg2", RG2, 8'h00);
    chk("rst_rg3", RG3, 8'h00);
    chk("rst_sel", {7'd0, seleccion}, 8'd0);
    chk("rst_field", {6'd0, field}, 8'd0);
    chk("rst_wr", {7'd0, wr_req}, 8'd0);
    chk("rst_blink", {7'd0, blink}, 8'd0);
    rst_n = 1'b1;
    tick();

    capture(2'd1, 8'h37);
    chk("cap_rg2", RG2, 8'h37);
    capture(2'd3, 8'h55);
    chk("cap3_rg1", RG1, 8'h00);
    chk("cap3_rg2", RG2, 8'h37);
    chk("cap3_rg3", RG3, 8'h00);
    chk("cap_sel_idle", {7'd0, seleccion}, 8'd0);

    capture(2'd0, 8'h23);
    capture(2'd1, 8'h09);
    press(1, 0, 1, 0);
    chk("idle_btn_rg1", RG1, 8'h23);
    chk("idle_btn_field", {6'd0, field}, 8'd0);

    enter_edit();
    chk("edit_sel", {7'd0, seleccion}, 8'd1);
    chk("edit_field0", {6'd0, field}, 8'd0);
    chk("blink_entry", {7'd0, blink}, blink_exp0);
    repeat (4) tick();
    chk("blink_wrap", {7'd0, blink}, blink_exp1);

    press(1, 0, 0, 0);
    chk("up_wrap_rg1", RG1, 8'h00);
    press(0, 0, 0, 1);
    press(1, 0, 0, 0);
    chk("up_carry_rg2", RG2, 8'h10);
    chk("field_after_right", {6'd0, field}, 8'd1);
    press(0, 0, 0, 1);
    press(0, 1, 0, 0);
    chk("down_wrap_rg3", RG3, 8'h59);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    chk("left_to_0", {6'd0, field}, 8'd0);
    press(0, 0, 1, 0);
    chk("left_wrap", {6'd0, field}, 8'd2);
    press(1, 1, 0, 0);
    chk("updown_rg3", RG3, 8'h59);
    press(0, 0, 1, 1);
    chk("leftright_field", {6'd0, field}, 8'd2);
    press(1, 0, 1, 0);
    chk("up_old_field_rg3", RG3, 8'h00);
    chk("up_then_move", {6'd0, field}, 8'd1);
    press(0, 1, 0, 1);
    chk("down_old_field_rg2", RG2, 8'h09);
    chk("down_then_move", {6'd0, field}, 8'd2);
    capture(2'd2, 8'h11);
    chk("cap_in_edit", RG3, 8'h00);

    edit_en = 1'b0;
    wr_cnt = 0; wr_at = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (wr_req) begin
        wr_cnt++;
        if (wr_at == 0) wr_at = i;
      end
    end
    chk("wr_pulses", 8'(wr_cnt), 8'd1);
    chk("wr_timing", 8'(wr_at), 8'd3);
    chk("sel_after_commit", {7'd0, seleccion}, 8'd0);
    chk("blink_idle", {7'd0, blink}, 8'd0);

    capture(2'd3, 8'h00);
    capture(2'd2, 8'h7A);
    enter_edit();
    chk("reenter_field", {6'd0, field}, 8'd0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    chk("invalid_up_rg3", RG3, 8'h00);
    capture(2'd1, 8'h77);
    press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    chk("down_borrow_rg2", RG2, 8'h08);
    capture(2'd0, 8'h45);
    press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    chk("outrange_down_rg1", RG1, 8'h23);

    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rg1", RG1, 8'h00);
    chk("mid_rst_rg2", RG2, 8'h00);
    chk("mid_rst_sel", {7'd0, seleccion}, 8'd0);
    chk("mid_rst_field", {6'd0, field}, 8'd0);
    edit_en = 1'b0;
    tick();
    rst_n = 1'b1;
    wr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wr_req) wr_cnt++;
    end
    chk("no_wr_on_rst", 8'(wr_cnt), 8'd0);
    chk("idle_after_rst", {7'd0, seleccion}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
